// File: rtl/riscv_core_pkg.sv
// riscv_core_pkg: shared types for the multi-cycle execute sequencer.
package riscv_core_pkg;
  localparam int MC_NUM_UNITS = 5;
  typedef enum logic [2:0] {MC_MUL = 3'd0, MC_DIV, MC_FPU, MC_VPU, MC_MLIU} mc_unit_e;
  typedef enum logic [1:0] {MC_IDLE, MC_REQ, MC_WAIT, MC_WB} mc_state_e;
endpackage

// File: rtl/multicycle_issue_ctrl.sv
// multicycle_issue_ctrl: issues one EX op to a multi-cycle unit, stalls the pipe,
// and returns the result to writeback with flush and timeout abort.
module multicycle_issue_ctrl
  import riscv_core_pkg::*;
#(
  parameter int NUM_UNITS   = MC_NUM_UNITS,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    issue_valid_i,
  input  logic [2:0]              issue_unit_i,
  input  logic [4:0]              issue_rd_i,
  input  logic                    flush_i,
  output logic [NUM_UNITS-1:0]    unit_req_o,
  input  logic [NUM_UNITS-1:0]    unit_gnt_i,
  input  logic [NUM_UNITS-1:0]    unit_done_i,
  input  logic [NUM_UNITS*32-1:0] unit_result_i,
  output logic [NUM_UNITS-1:0]    unit_abort_o,
  output logic                    stall_o,
  output logic                    wb_valid_o,
  output logic [4:0]              wb_rd_o,
  output logic [31:0]             wb_data_o,
  input  logic                    wb_ready_i,
  output logic                    busy_o,
  output logic                    timeout_o
);
  localparam int CW = $clog2(TIMEOUT_CYC);
  mc_state_e state_q, state_d;
  logic [2:0] sel_q, sel_d;
  logic [4:0] rd_q, rd_d;
  logic [31:0] data_q, data_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic accept, sel_gnt, sel_done, timeout_hit, capture;
  logic [NUM_UNITS-1:0] onehot;
  logic [31:0] sel_result;
  assign accept      = issue_valid_i & ~flush_i & (32'(issue_unit_i) < NUM_UNITS);
  assign sel_gnt     = unit_gnt_i[sel_q];
  assign sel_done    = unit_done_i[sel_q];
  assign sel_result  = unit_result_i[32*sel_q +: 32];
  assign timeout_hit = cnt_q == CW'(TIMEOUT_CYC - 1);
  assign capture     = ~flush_i & sel_done & ((state_q == MC_REQ & sel_gnt) | state_q == MC_WAIT);
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= MC_IDLE;
    else state_q <= state_d;
  end
  // Flush outranks every other event; done outranks timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      MC_IDLE: state_d = accept ? MC_REQ : MC_IDLE;
      MC_REQ:  state_d = flush_i ? MC_IDLE : !sel_gnt ? MC_REQ : sel_done ? MC_WB : MC_WAIT;
      MC_WAIT: state_d = flush_i ? MC_IDLE : sel_done ? MC_WB : timeout_hit ? MC_IDLE : MC_WAIT;
      MC_WB:   state_d = (flush_i | wb_ready_i) ? MC_IDLE : MC_WB;
      default: state_d = MC_IDLE;
    endcase
  end
  always_comb begin
    onehot         = '0;
    onehot[sel_q]  = 1'b1;
    unit_req_o     = (state_q == MC_REQ & ~flush_i) ? onehot : '0;
    timeout_o      = state_q == MC_WAIT & ~flush_i & ~sel_done & timeout_hit;
    unit_abort_o   = (((state_q == MC_REQ | state_q == MC_WAIT) & flush_i) | timeout_o) ? onehot : '0;
    stall_o        = (state_q == MC_IDLE & accept) | state_q == MC_REQ | state_q == MC_WAIT |
                     (state_q == MC_WB & ~wb_ready_i);
    wb_valid_o     = state_q == MC_WB;
    busy_o         = state_q != MC_IDLE;
    wb_rd_o        = rd_q;
    wb_data_o      = data_q;
  end
  always_comb begin
    sel_d  = (state_q == MC_IDLE & accept) ? issue_unit_i : sel_q;
    rd_d   = (state_q == MC_IDLE & accept) ? issue_rd_i : rd_q;
    data_d = capture ? sel_result : data_q;
    cnt_d  = state_q == MC_REQ ? '0 : (state_q == MC_WAIT & ~timeout_hit) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sel_q  <= '0;
      rd_q   <= '0;
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      sel_q  <= sel_d;
      rd_q   <= rd_d;
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end
endmodule

// File: tb/tb_multicycle_issue_ctrl.sv
// tb_multicycle_issue_ctrl: directed vectors with hand-computed expectations.
module tb_multicycle_issue_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  logic issue_valid = 1'b0, flush = 1'b0, wb_ready = 1'b0;
  logic [2:0] issue_unit = '0;
  logic [4:0] issue_rd = '0;
  logic [4:0] gnt = '0, done = '0;
  logic [159:0] res = '0;
  logic [4:0] req, abort;
  logic stall, wb_valid, busy, tmo;
  logic [4:0] wb_rd;
  logic [31:0] wb_data;
  int n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;
  multicycle_issue_ctrl #(.NUM_UNITS(5), .TIMEOUT_CYC(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .issue_valid_i(issue_valid), .issue_unit_i(issue_unit),
    .issue_rd_i(issue_rd), .flush_i(flush), .unit_req_o(req), .unit_gnt_i(gnt),
    .unit_done_i(done), .unit_result_i(res), .unit_abort_o(abort), .stall_o(stall),
    .wb_valid_o(wb_valid), .wb_rd_o(wb_rd), .wb_data_o(wb_data), .wb_ready_i(wb_ready),
    .busy_o(busy), .timeout_o(tmo)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask
  task automatic settle();
    #1;
  endtask
  initial begin
    #2;
    chk("rst_stall", stall, 0); chk("rst_busy", busy, 0); chk("rst_req", req, 0);
    chk("rst_wbv", wb_valid, 0); chk("rst_data", wb_data, 0); chk("rst_abort", abort, 0);
    #20 rst_n = 1'b1;
    nxt();
    // MUL: gnt in first REQ cycle, done in third WAIT cycle
    issue_valid = 1; issue_unit = 3'd0; issue_rd = 5'd5; settle();
    chk("mul_iss_stall", stall, 1); chk("mul_iss_busy", busy, 0);
    nxt(); issue_valid = 0; gnt = 5'b00001; settle();
    chk("mul_req", req, 5'b00001); chk("mul_req_stall", stall, 1);
    nxt(); gnt = 0; settle();
    chk("mul_wait_req", req, 0); chk("mul_wait_stall", stall, 1);
    nxt(); nxt(); done = 5'b00001; res[31:0] = 32'h12345678; settle();
    chk("mul_done_wbv", wb_valid, 0);
    nxt(); done = 0; wb_ready = 1; settle();
    chk("mul_wbv", wb_valid, 1); chk("mul_rd", wb_rd, 5); chk("mul_data", wb_data, 32'h12345678);
    chk("mul_wb_stall", stall, 0);
    nxt(); wb_ready = 0; settle();
    chk("mul_after_wbv", wb_valid, 0); chk("mul_after_stall", stall, 0); chk("mul_after_busy", busy, 0);
    // DIV: grant arrives in the 4th REQ cycle
    issue_valid = 1; issue_unit = 3'd1; issue_rd = 5'd7;
    nxt(); issue_valid = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) gnt = 5'b00010;
      settle();
      chk($sformatf("div_req%0d", i), req, 5'b00010); chk($sformatf("div_stall%0d", i), stall, 1);
      nxt();
    end
    gnt = 0; settle();
    chk("div_wait_req", req, 0); chk("div_wait_stall", stall, 1);
    done = 5'b00010; res[63:32] = 32'hDEAD0001;
    nxt(); done = 0; wb_ready = 1; settle();
    chk("div_wbv", wb_valid, 1); chk("div_data", wb_data, 32'hDEAD0001); chk("div_rd", wb_rd, 7);
    nxt(); wb_ready = 0;
    // FPU flushed while waiting
    issue_valid = 1; issue_unit = 3'd2; issue_rd = 5'd9;
    nxt(); issue_valid = 0; gnt = 5'b00100;
    nxt(); gnt = 0;
    nxt(); flush = 1; settle();
    chk("fpu_abort", abort, 5'b00100); chk("fpu_flush_wbv", wb_valid, 0); chk("fpu_flush_tmo", tmo, 0);
    nxt(); flush = 0; settle();
    chk("fpu_abort_off", abort, 0); chk("fpu_busy", busy, 0); chk("fpu_wbv", wb_valid, 0);
    // VPU never completes: abort on the 8th WAIT cycle
    issue_valid = 1; issue_unit = 3'd3; issue_rd = 5'd2;
    nxt(); issue_valid = 0; gnt = 5'b01000;
    nxt(); gnt = 0;
    for (int k = 0; k < 8; k++) begin
      settle();
      chk($sformatf("vpu_tmo%0d", k), tmo, k == 7);
      chk($sformatf("vpu_abort%0d", k), abort, k == 7 ? 5'b01000 : 5'b00000);
      chk($sformatf("vpu_stall%0d", k), stall, 1);
      nxt();
    end
    settle();
    chk("vpu_busy", busy, 0); chk("vpu_wbv", wb_valid, 0); chk("vpu_tmo_off", tmo, 0);
    chk("vpu_abort_off", abort, 0);
    // MLIU: gnt and done together, writeback back-pressured 3 cycles
    issue_valid = 1; issue_unit = 3'd4; issue_rd = 5'd31;
    nxt(); issue_valid = 0; gnt = 5'b10000; done = 5'b10000; res[159:128] = 32'hCAFEBABE;
    nxt(); gnt = 0; done = 0; res[159:128] = 32'h0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk($sformatf("mliu_wbv%0d", i), wb_valid, 1); chk($sformatf("mliu_data%0d", i), wb_data, 32'hCAFEBABE);
      chk($sformatf("mliu_rd%0d", i), wb_rd, 31); chk($sformatf("mliu_stall%0d", i), stall, 1);
      nxt();
    end
    wb_ready = 1; settle();
    chk("mliu_rel_stall", stall, 0); chk("mliu_rel_wbv", wb_valid, 1);
    nxt(); wb_ready = 0; settle();
    chk("mliu_busy", busy, 0);
    // Out-of-range unit is ignored
    issue_valid = 1; issue_unit = 3'd7; issue_rd = 5'd4; settle();
    chk("oor_stall", stall, 0);
    nxt(); issue_valid = 0; settle();
    chk("oor_req", req, 0); chk("oor_busy", busy, 0);
    // Non-selected gnt/done are ignored
    issue_valid = 1; issue_unit = 3'd0; issue_rd = 5'd3;
    nxt(); issue_valid = 0; gnt = 5'b00010;
    nxt(); settle();
    chk("foreign_gnt_req", req, 5'b00001);
    gnt = 5'b00001;
    nxt(); gnt = 0; done = 5'b00010; res[63:32] = 32'h11111111;
    nxt(); done = 0; settle();
    chk("foreign_done_busy", busy, 1); chk("foreign_done_wbv", wb_valid, 0);
    done = 5'b00001; res[31:0] = 32'h0BADF00D;
    nxt(); done = 0; wb_ready = 1; settle();
    chk("own_done_data", wb_data, 32'h0BADF00D); chk("own_done_rd", wb_rd, 3);
    nxt(); wb_ready = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
